// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: valid/ready bundle carrying the raw immediate in and the extended result out.
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] imm;
    logic [1:0]      mode;
    logic            out_valid;
    logic            out_ready;
    logic [OUT_W-1:0] ext_out;

    modport master (
        output in_valid, imm, mode, out_ready,
        input  in_ready, out_valid, ext_out
    );

    modport slave (
        input  in_valid, imm, mode, out_ready,
        output in_ready, out_valid, ext_out
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate extender (sign/zero/upper/shl2) with valid/ready flow control.
// Define IMX_SKID_EN to add a skid register so in_ready no longer depends combinationally on out_ready.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    imm_extend_pipe_if.slave   bus
);
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] out_q;
    logic             out_v;
    logic             acc;

    always_comb begin
        sext = {{(OUT_W-IN_W){bus.imm[IN_W-1]}}, bus.imm};
        ext  = bus.mode[1]
             ? (bus.mode[0] ? {sext[OUT_W-3:0], 2'b00} : {bus.imm, {(OUT_W-IN_W){1'b0}}})
             : (bus.mode[0] ? {{(OUT_W-IN_W){1'b0}}, bus.imm} : sext);
    end

    assign acc           = bus.in_valid & bus.in_ready;
    assign bus.ext_out   = out_q;
    assign bus.out_valid = out_v;

`ifdef IMX_SKID_EN
    logic [OUT_W-1:0] skid_q;
    logic             skid_v;

    assign bus.in_ready = rst_n & ~skid_v;

    // The skid only ever fills while the output is full and stalled, so it drains first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= '0;
            out_v  <= 1'b0;
            skid_q <= '0;
            skid_v <= 1'b0;
        end else if (bus.out_ready | ~out_v) begin
            out_v  <= skid_v | acc;
            out_q  <= skid_v ? skid_q : (acc ? ext : out_q);
            skid_v <= 1'b0;
        end else if (acc) begin
            skid_q <= ext;
            skid_v <= 1'b1;
        end
    end
`else
    assign bus.in_ready = rst_n & (~out_v | bus.out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
            out_v <= 1'b0;
        end else if (acc) begin
            out_q <= ext;
            out_v <= 1'b1;
        end else if (bus.out_ready) begin
            out_v <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed vectors into a scoreboard queue, popped by a monitor on each output transfer.
module tb_imm_extend_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) b ();
    imm_extend_pipe_if #(.IN_W(8),  .OUT_W(16)) b8 ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    imm_extend_pipe #(.IN_W(8),  .OUT_W(16)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

`ifdef IMX_SKID_EN
    localparam int EXP_ACC = 2;
`else
    localparam int EXP_ACC = 1;
`endif

    logic [31:0] q[$];
    logic [15:0] q8[$];
    int n_cmp = 0;
    int n_bad = 0;
    int acc_cnt = 0;
    int cyc = 0;
    int c0, a0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && b.out_valid && b.out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out_extra: got %h expected nothing", b.ext_out);
            end else check("out", b.ext_out, q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && b8.out_valid && b8.out_ready) begin
            if (q8.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out8_extra: got %h expected nothing", b8.ext_out);
            end else check("out8", {16'h0, b8.ext_out}, {16'h0, q8.pop_front()});
        end
    end

    task automatic send(input logic [15:0] i, input logic [1:0] m, input logic [31:0] e);
        b.in_valid = 1'b1;
        b.imm = i;
        b.mode = m;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (b.in_ready) begin
                q.push_back(e);
                @(posedge clk);
                #1;
                acc_cnt++;
                b.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got no accept expected accept of %h", i);
        b.in_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] i, input logic [1:0] m, input logic [15:0] e);
        b8.in_valid = 1'b1;
        b8.imm = i;
        b8.mode = m;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (b8.in_ready) begin
                q8.push_back(e);
                @(posedge clk);
                #1;
                b8.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL send8_timeout: got no accept expected accept of %h", i);
        b8.in_valid = 1'b0;
    endtask

    task automatic drain;
        for (int k = 0; k < 50 && (q.size() != 0 || q8.size() != 0); k++) @(negedge clk);
        check("drain", q.size() + q8.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b.in_valid = 1'b0; b.imm = '0; b.mode = '0; b.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.imm = '0; b8.mode = '0; b8.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", b.out_valid, 0);
        check("rst_ext_out", b.ext_out, 0);
        check("rst_in_ready", b.in_ready, 0);
        rst_n = 1'b1;

        send(16'h2FBD, 2'b00, 32'h0000_2FBD);
        check("lat_valid", b.out_valid, 1);
        check("lat_data", b.ext_out, 32'h0000_2FBD);

        c0 = cyc;
        send(16'h8001, 2'b00, 32'hFFFF_8001);
        send(16'h8001, 2'b01, 32'h0000_8001);
        send(16'h8001, 2'b10, 32'h8001_0000);
        send(16'h8001, 2'b11, 32'hFFFE_0004);
        check("throughput_cycles", cyc - c0, 4);

        send(16'hFFFF, 2'b11, 32'hFFFF_FFFC);
        send(16'h7FFF, 2'b10, 32'h7FFF_0000);
        send(16'h1234, 2'b11, 32'h0000_48D0);

        send8(8'h80, 2'b00, 16'hFF80);
        send8(8'h80, 2'b10, 16'h8000);
        send8(8'h7F, 2'b11, 16'h01FC);
        send8(8'h80, 2'b01, 16'h0080);
        drain();

        // Stall downstream while three items are offered.
        b.out_ready = 1'b0;
        a0 = acc_cnt;
        fork
            begin
                send(16'h0001, 2'b01, 32'h1);
                send(16'h0002, 2'b01, 32'h2);
                send(16'h0003, 2'b01, 32'h3);
            end
            begin
                repeat (2) @(posedge clk);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall_valid", b.out_valid, 1);
                    check("stall_hold", b.ext_out, 32'h1);
                end
                check("stall_accepts", acc_cnt - a0, EXP_ACC);
                check("stall_in_ready", b.in_ready, 0);
                @(posedge clk);
                #1;
                b.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with the output (and skid, when present) full.
        b.out_ready = 1'b0;
        send(16'h00AA, 2'b01, 32'hAA);
`ifdef IMX_SKID_EN
        send(16'h00BB, 2'b01, 32'hBB);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", b.in_ready, 0);
        @(posedge clk);
        #1;
        check("midrst_out_valid", b.out_valid, 0);
        check("midrst_ext_out", b.ext_out, 0);
        check("midrst_in_ready_after", b.in_ready, 0);
        q.delete();
        rst_n = 1'b1;
        b.out_ready = 1'b1;
        send(16'h0005, 2'b01, 32'h0000_0005);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, meaning immediate input width in bits.
REQ-002 SHALL have parameter OUT_W, default 32, meaning extended output width in bits; legal only if OUT_W >= IN_W+2.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port IN_VALID  input  1  upstream holds a valid IMM/MODE pair.
REQ-006 SHALL have port IN_READY  output  1  block accepts IMM/MODE this cycle.
REQ-007 SHALL have port IMM  input  IN_W  raw immediate field.
REQ-008 SHALL have port MODE  input  2  extension mode: 00 SIGN, 01 ZERO, 10 UPPER, 11 SHL2.
REQ-009 SHALL have port OUT_VALID  output  1  EXT_OUT holds a valid result.
REQ-010 SHALL have port OUT_READY  input  1  downstream consumes EXT_OUT this cycle.
REQ-011 SHALL have port EXT_OUT  output  OUT_W  extended immediate, driven from a register.

Function
REQ-012 SHALL accept an input on any edge where IN_VALID and IN_READY are both 1, and SHALL transfer an output on any edge where OUT_VALID and OUT_READY are both 1.
REQ-013 SHALL compute SIGN as IMM replicated-MSB to OUT_W bits.
REQ-014 SHALL compute ZERO as IMM padded with zeros to OUT_W bits.
REQ-015 SHALL compute UPPER as IMM in bits [OUT_W-1:OUT_W-IN_W], all lower bits 0.
REQ-016 SHALL compute SHL2 as the SIGN result shifted left by 2, upper 2 bits discarded, bits [1:0] = 0.
REQ-017 SHALL register the result: an input accepted on edge N SHALL appear on EXT_OUT with OUT_VALID=1 after edge N (latency 1 cycle) when the output register is empty or drained on edge N.
REQ-018 SHALL hold EXT_OUT and OUT_VALID stable while OUT_VALID=1 and OUT_READY=0.
REQ-019 SHALL sustain one transfer per cycle when IN_VALID and OUT_READY are continuously 1.
REQ-020 SHALL deliver results in acceptance order; no result dropped or duplicated.
REQ-021 SHALL, on simultaneous output drain and input accept with an empty skid (REQ-029), load the new result into the output register on that edge.
REQ-022 SHALL ignore IMM and MODE whenever IN_VALID=0 or IN_READY=0.

Reset
REQ-023 SHALL, on any edge with RST_N=0, clear OUT_VALID to 0, EXT_OUT to 0, and all internal valid flags to 0, regardless of handshake state.
REQ-024 SHALL drive IN_READY=0 while RST_N=0.
REQ-025 SHALL discard any in-flight or buffered result on reset mid-operation; first output after reset comes only from an input accepted after RST_N returns to 1.

Configuration
REQ-026 SHALL use macro IMX_SKID_EN to select the output buffering structure.
REQ-027 SHALL, without IMX_SKID_EN, use one output register with IN_READY = RST_N & (~OUT_VALID | OUT_READY) (combinational path from OUT_READY).
REQ-028 SHALL, with IMX_SKID_EN, add one skid register so IN_READY is a registered signal independent of OUT_READY in the same cycle.
REQ-029 SHALL, with IMX_SKID_EN: IN_READY = ~skid_valid; accept while output full and stalled writes skid; on drain, output loads from skid if skid_valid else from the accepted input; skid clears when emptied.
REQ-030 SHALL, with IMX_SKID_EN, deassert IN_READY the cycle after skid fills and reassert it the cycle after skid drains.

Verification
REQ-031 SHALL check: IMM=16'h2FBD, MODE=00, OUT_READY=1 -> EXT_OUT=32'h00002FBD, OUT_VALID=1 one cycle after accept.
REQ-032 SHALL check: IMM=16'h8001 with MODE 00/01/10/11 back-to-back -> 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004, one per cycle, in order.
REQ-033 SHALL check: OUT_READY=0 for 5 cycles while IN_VALID=1 with IMM 1,2,3 -> EXT_OUT holds 32'h1 stable; IN_READY=0 after 1 (no macro) or 2 (IMX_SKID_EN) accepts; on release outputs 1,2,3 with no loss.
REQ-034 SHALL check: IMM=16'hFFFF, MODE=11 -> EXT_OUT=32'hFFFFFFFC.
REQ-035 SHALL check: RST_N=0 for one edge while output and skid full -> OUT_VALID=0, EXT_OUT=0, IN_READY=0 that cycle; next accepted IMM=16'h0005 MODE=01 yields 32'h00000005 as first output.
REQ-036 SHALL check with IN_W=8, OUT_W=16: IMM=8'h80 MODE=00 -> 16'hFF80; MODE=10 -> 16'h8000.
